// File: rtl/cardinal_nic.sv
// Network interface between one processor and one router PE port.
// Single-entry output/input channel buffers with polarity-gated injection.
module cardinal_nic #(
    parameter int DATA_W = 64,
    parameter int VC_BIT = 63
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    input  logic              nicEn,
    input  logic              nicWrEn,
    output logic              net_si,
    input  logic              net_ri,
    output logic [DATA_W-1:0] net_do,
    input  logic              net_so,
    output logic              net_ro,
    input  logic [DATA_W-1:0] net_di,
    input  logic              net_polarity
);

    localparam logic [1:0] ADDR_IN_BUF     = 2'b00;
    localparam logic [1:0] ADDR_IN_STATUS  = 2'b01;
    localparam logic [1:0] ADDR_OUT_BUF    = 2'b10;
    localparam logic [1:0] ADDR_OUT_STATUS = 2'b11;

    logic [DATA_W-1:0] out_buf;
    logic [DATA_W-1:0] in_buf;
    logic              out_full;
    logic              in_full;

    logic rd_en;
    logic wr_out;
    logic rd_in_buf;

    assign rd_en     = nicEn & ~nicWrEn;
    assign wr_out    = nicEn & nicWrEn & (addr == ADDR_OUT_BUF) & ~out_full;
    assign rd_in_buf = rd_en & (addr == ADDR_IN_BUF) & in_full;

    // Inject only when the packet's VC is opposite the router's current phase.
    assign net_si = ~reset & out_full & net_ri & (out_buf[VC_BIT] != net_polarity);
    assign net_ro = ~in_full & ~reset;
    assign net_do = out_buf;

    always_comb begin
        d_out = '0;
        if (!reset && rd_en) begin
            case (addr)
                ADDR_IN_BUF:     d_out = in_buf;
                ADDR_IN_STATUS:  d_out = {{(DATA_W-1){1'b0}}, in_full};
                ADDR_OUT_STATUS: d_out = {{(DATA_W-1){1'b0}}, out_full};
                default:         d_out = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_buf  <= '0;
            out_full <= 1'b0;
            in_buf   <= '0;
            in_full  <= 1'b0;
        end else begin
            // wr_out requires empty and net_si requires full, so they never coincide.
            if (net_si) begin
                out_full <= 1'b0;
            end else if (wr_out) begin
                out_buf  <= d_in;
                out_full <= 1'b1;
            end

            if (net_so && net_ro) begin
                in_buf  <= net_di;
                in_full <= 1'b1;
            end else if (rd_in_buf) begin
                in_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cardinal_nic.sv
// Self-checking bench for cardinal_nic: directed scenarios plus random traffic
// compared against a channel-level model (each direction holds at most one packet).
module tb_cardinal_nic;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic [63:0] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_do;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_di;
    logic        net_polarity;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] out_q[$];
    logic [63:0] in_q[$];
    logic [63:0] last_out;
    logic [63:0] last_in;

    cardinal_nic #(.DATA_W(64), .VC_BIT(63)) dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_do       (net_do),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_di       (net_di),
        .net_polarity (net_polarity)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Drive one cycle of inputs, check outputs against the model, then advance the model.
    task automatic step(input logic rst, input logic en, input logic wr, input logic [1:0] a,
                        input logic [63:0] din, input logic ri, input logic so,
                        input logic [63:0] di, input logic pol);
        logic        e_si;
        logic        e_ro;
        logic [63:0] e_dout;
        @(negedge clk);
        reset = rst; nicEn = en; nicWrEn = wr; addr = a; d_in = din;
        net_ri = ri; net_so = so; net_di = di; net_polarity = pol;
        #1;
        e_si = !rst && out_q.size() == 1 && ri && (out_q[0][63] != pol);
        e_ro = !rst && in_q.size() == 0;
        e_dout = 64'd0;
        if (!rst && en && !wr) begin
            case (a)
                2'b00: e_dout = last_in;
                2'b01: e_dout = 64'(in_q.size());
                2'b11: e_dout = 64'(out_q.size());
                default: e_dout = 64'd0;
            endcase
        end
        chk("net_si", {63'd0, net_si}, {63'd0, e_si});
        chk("net_ro", {63'd0, net_ro}, {63'd0, e_ro});
        chk("net_do", net_do, last_out);
        chk("d_out", d_out, e_dout);
        if (rst) begin
            out_q.delete(); in_q.delete();
            last_out = 64'd0; last_in = 64'd0;
        end else begin
            if (e_si) void'(out_q.pop_front());
            else if (en && wr && a == 2'b10 && out_q.size() == 0) begin
                out_q.push_back(din); last_out = din;
            end
            if (so && e_ro) begin
                in_q.push_back(di); last_in = di;
            end else if (en && !wr && a == 2'b00 && in_q.size() == 1) begin
                void'(in_q.pop_front());
            end
        end
    endtask

    function automatic logic [63:0] r64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        reset = 1'b1; nicEn = 0; nicWrEn = 0; addr = 0; d_in = 0;
        net_ri = 0; net_so = 0; net_di = 0; net_polarity = 0;
        last_out = 0; last_in = 0;

        // Reset with inputs toggling
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 1'(i), 2'(i), r64(), 1, 1, r64(), 1'(i));
            chk("rst_si", {63'd0, net_si}, 64'd0);
            chk("rst_ro", {63'd0, net_ro}, 64'd0);
        end
        step(1, 1, 0, 2'b00, 0, 1, 1, r64(), 0);
        chk("rst_dout", d_out, 64'd0);
        step(0, 1, 0, 2'b01, 0, 0, 0, 0, 0);
        chk("post_rst_in_status", d_out, 64'd0);
        chk("post_rst_ro", {63'd0, net_ro}, 64'd1);
        step(0, 1, 0, 2'b11, 0, 0, 0, 0, 0);
        chk("post_rst_out_status", d_out, 64'd0);

        // Send with phase gating
        step(0, 1, 1, 2'b10, 64'h8000_0000_0000_00AA, 0, 0, 0, 0);
        step(0, 0, 0, 2'b00, 0, 1, 0, 0, 1);
        chk("phase_stall_si", {63'd0, net_si}, 64'd0);
        step(0, 0, 0, 2'b00, 0, 1, 0, 0, 0);
        chk("phase_send_si", {63'd0, net_si}, 64'd1);
        chk("phase_send_do", net_do, 64'h8000_0000_0000_00AA);
        step(0, 1, 0, 2'b11, 0, 1, 0, 0, 0);
        chk("after_send_status", d_out, 64'd0);

        // Backpressure and dropped second write
        step(0, 1, 1, 2'b10, 64'h11, 0, 0, 0, 0);
        step(0, 1, 1, 2'b10, 64'h22, 0, 0, 0, 0);
        step(0, 1, 0, 2'b11, 0, 0, 0, 0, 1);
        chk("bp_out_status", d_out, 64'd1);
        chk("bp_si", {63'd0, net_si}, 64'd0);
        step(0, 0, 0, 2'b00, 0, 1, 0, 0, 1);
        chk("bp_send_si", {63'd0, net_si}, 64'd1);
        chk("bp_send_do", net_do, 64'h11);
        step(0, 1, 0, 2'b11, 0, 1, 0, 0, 1);
        chk("bp_done_status", d_out, 64'd0);
        chk("bp_no_22", net_do, 64'h11);

        // Receive
        step(0, 0, 0, 2'b00, 0, 0, 1, 64'h0123_4567_89AB_CDEF, 0);
        step(0, 1, 0, 2'b01, 0, 0, 0, 0, 0);
        chk("rx_ro_low", {63'd0, net_ro}, 64'd0);
        chk("rx_in_status", d_out, 64'd1);
        step(0, 1, 0, 2'b00, 0, 0, 0, 0, 0);
        chk("rx_data", d_out, 64'h0123_4567_89AB_CDEF);
        step(0, 1, 0, 2'b01, 0, 0, 0, 0, 0);
        chk("rx_ro_back", {63'd0, net_ro}, 64'd1);
        chk("rx_status_clear", d_out, 64'd0);

        // Input full: router holds 0x55 while the buffer is occupied
        step(0, 0, 0, 2'b00, 0, 0, 1, 64'hAB, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 2'b00, 0, 0, 1, 64'h55, 0);
            chk("full_ro", {63'd0, net_ro}, 64'd0);
        end
        step(0, 1, 0, 2'b00, 0, 0, 1, 64'h55, 0);
        chk("full_kept", d_out, 64'hAB);
        step(0, 0, 0, 2'b00, 0, 0, 1, 64'h55, 0);
        chk("full_ro_free", {63'd0, net_ro}, 64'd1);
        step(0, 1, 0, 2'b00, 0, 0, 0, 0, 0);
        chk("full_captured", d_out, 64'h55);

        // Reset mid-operation
        step(0, 1, 1, 2'b10, 64'h8000_0000_0000_0077, 0, 1, 64'h66, 1);
        step(1, 0, 0, 2'b00, 0, 1, 1, 64'h99, 0);
        chk("midrst_si", {63'd0, net_si}, 64'd0);
        step(0, 1, 0, 2'b01, 0, 1, 0, 0, 0);
        chk("midrst_in_status", d_out, 64'd0);
        chk("midrst_si_after", {63'd0, net_si}, 64'd0);
        step(0, 1, 0, 2'b11, 0, 1, 0, 0, 0);
        chk("midrst_out_status", d_out, 64'd0);

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 49) == 0), 1'($urandom()), 1'($urandom()),
                 2'($urandom()), r64(), ($urandom_range(0, 3) != 0),
                 1'($urandom()), r64(), 1'($urandom()));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
